// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - command table, frame lengths and enums shared by the UART command framer
package uart_cmd_pkg;

    localparam logic [7:0] CMD_HORNET_KEY     = 8'h40;
    localparam logic [7:0] CMD_SHOOTING_FLAGS = 8'h41;
    localparam logic [7:0] CMD_AES_KEY        = 8'h42;
    localparam logic [7:0] CMD_AES_PT         = 8'h43;
    localparam logic [7:0] CMD_AES_ENC_OUT    = 8'h44;
    localparam logic [7:0] CMD_AES_DEC_OUT    = 8'h45;

    localparam int SHORT_LEN = 3;
    localparam int LONG_LEN  = 18;

    // Index of the end-delimiter byte within each frame type
    localparam logic [4:0] SHORT_LAST = 5'(SHORT_LEN - 1);
    localparam logic [4:0] LONG_LAST  = 5'(LONG_LEN - 1);

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_UNKNOWN  = 2'd1,
        ERR_MISMATCH = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

endpackage

// File: rtl/uart_cmd_framer_if.sv
// rtl/uart_cmd_framer_if.sv - received-byte input and command/error strobe outputs of the framer
interface uart_cmd_framer_if;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         cmd_valid;
    logic [7:0]   cmd_code;
    logic [7:0]   cmd_arg;
    logic [127:0] cmd_payload;
    logic         err_valid;
    logic [1:0]   err_code;

    modport master (
        output rx_data, rx_valid,
        input  cmd_valid, cmd_code, cmd_arg, cmd_payload, err_valid, err_code
    );

    modport slave (
        input  rx_data, rx_valid,
        output cmd_valid, cmd_code, cmd_arg, cmd_payload, err_valid, err_code
    );
endinterface

// File: rtl/uart_cmd_lookup.sv
// rtl/uart_cmd_lookup.sv - decodes a command byte into known / long-frame flags
module uart_cmd_lookup
    import uart_cmd_pkg::*;
(
    input  logic [7:0] i_code,
    output logic       o_known,
    output logic       o_is_long
);

    always_comb begin
        o_known   = 1'b0;
        o_is_long = 1'b0;
        case (i_code)
            CMD_SHOOTING_FLAGS: o_known = 1'b1;
            CMD_HORNET_KEY, CMD_AES_KEY, CMD_AES_PT,
            CMD_AES_ENC_OUT, CMD_AES_DEC_OUT: begin
                o_known   = 1'b1;
                o_is_long = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/uart_cmd_framer.sv
// rtl/uart_cmd_framer.sv - assembles UART bytes into delimited command frames with timeout and error reporting
module uart_cmd_framer
    import uart_cmd_pkg::*;
#(
    parameter int CLK_FREQ       = 103_340_000,
    parameter int TIMEOUT_CYCLES = 10_334_000,
    parameter int CNT_BITS       = 24
) (
    input  logic           clk,
    input  logic           reset,
    uart_cmd_framer_if.slave bus
);

    if (CLK_FREQ <= 0 || TIMEOUT_CYCLES < 1 ||
        64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_BITS)) begin : g_param_check
        $error("uart_cmd_framer: TIMEOUT_CYCLES does not fit in CNT_BITS");
    end

    localparam logic [CNT_BITS-1:0] TMO_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

    state_e              r_state,       w_state_n;
    logic [4:0]          r_idx,         w_idx_n;
    logic [CNT_BITS-1:0] r_tmo,         w_tmo_n;
    logic [7:0]          r_code,        w_code_n;
    logic                r_is_long,     w_is_long_n;
    logic [127:0]        r_payload,     w_payload_n;
    logic                r_cmd_valid,   w_cmd_valid_n;
    logic [7:0]          r_cmd_code,    w_cmd_code_n;
    logic [7:0]          r_cmd_arg,     w_cmd_arg_n;
    logic [127:0]        r_cmd_payload, w_cmd_payload_n;
    logic                r_err_valid,   w_err_valid_n;
    err_code_e           r_err_code,    w_err_code_n;

    logic       w_known;
    logic       w_is_long;
    logic [4:0] w_last;

    uart_cmd_lookup u_lookup (
        .i_code    (bus.rx_data),
        .o_known   (w_known),
        .o_is_long (w_is_long)
    );

    assign w_last = r_is_long ? LONG_LAST : SHORT_LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_n;
    end

    always_comb begin
        w_state_n       = r_state;
        w_idx_n         = r_idx;
        w_tmo_n         = r_tmo;
        w_code_n        = r_code;
        w_is_long_n     = r_is_long;
        w_payload_n     = r_payload;
        w_cmd_valid_n   = 1'b0;
        w_cmd_code_n    = r_cmd_code;
        w_cmd_arg_n     = r_cmd_arg;
        w_cmd_payload_n = r_cmd_payload;
        w_err_valid_n   = 1'b0;
        w_err_code_n    = ERR_NONE;

        case (r_state)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (w_known) begin
                        w_code_n    = bus.rx_data;
                        w_is_long_n = w_is_long;
                        w_payload_n = '0;
                        w_idx_n     = 5'd1;
                        w_tmo_n     = '0;
                        w_state_n   = ST_COLLECT;
                    end else begin
                        w_err_valid_n = 1'b1;
                        w_err_code_n  = ERR_UNKNOWN;
                    end
                end
            end
            ST_COLLECT: begin
                if (bus.rx_valid) begin
                    w_tmo_n = '0;
                    if (r_idx < w_last) begin
                        for (int i = 0; i < 16; i++) begin
                            if (r_idx == 5'(i + 1)) w_payload_n[8*i +: 8] = bus.rx_data;
                        end
                        w_idx_n = r_idx + 5'd1;
                    end else begin
                        // End delimiter: only this position is compared against the code
                        if (bus.rx_data == r_code) begin
                            w_cmd_valid_n   = 1'b1;
                            w_cmd_code_n    = r_code;
                            w_cmd_arg_n     = r_payload[7:0];
                            w_cmd_payload_n = r_payload;
                        end else begin
                            w_err_valid_n = 1'b1;
                            w_err_code_n  = ERR_MISMATCH;
                        end
                        w_idx_n   = '0;
                        w_state_n = ST_IDLE;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_err_valid_n = 1'b1;
                    w_err_code_n  = ERR_TIMEOUT;
                    w_tmo_n       = '0;
                    w_idx_n       = '0;
                    w_state_n     = ST_IDLE;
                end else if (r_tmo != '1) begin
                    w_tmo_n = r_tmo + 1'b1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx         <= '0;
            r_tmo         <= '0;
            r_code        <= '0;
            r_is_long     <= 1'b0;
            r_payload     <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_code    <= '0;
            r_cmd_arg     <= '0;
            r_cmd_payload <= '0;
            r_err_valid   <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else begin
            r_idx         <= w_idx_n;
            r_tmo         <= w_tmo_n;
            r_code        <= w_code_n;
            r_is_long     <= w_is_long_n;
            r_payload     <= w_payload_n;
            r_cmd_valid   <= w_cmd_valid_n;
            r_cmd_code    <= w_cmd_code_n;
            r_cmd_arg     <= w_cmd_arg_n;
            r_cmd_payload <= w_cmd_payload_n;
            r_err_valid   <= w_err_valid_n;
            r_err_code    <= w_err_code_n;
        end
    end

    assign bus.cmd_valid   = r_cmd_valid;
    assign bus.cmd_code    = r_cmd_code;
    assign bus.cmd_arg     = r_cmd_arg;
    assign bus.cmd_payload = r_cmd_payload;
    assign bus.err_valid   = r_err_valid;
    assign bus.err_code    = r_err_code;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb/tb_uart_cmd_framer.sv - directed self-checking bench for uart_cmd_framer
module tb_uart_cmd_framer;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   cyc;

    uart_cmd_framer_if bus();

    uart_cmd_framer #(
        .CLK_FREQ       (103_340_000),
        .TIMEOUT_CYCLES (100),
        .CNT_BITS       (24)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    int           n_cmd;
    int           n_err;
    int           cmd_cyc;
    int           err_cyc;
    logic [1:0]   last_err;
    logic         both_high;
    logic [7:0]   log_code    [32];
    logic [7:0]   log_arg     [32];
    logic [127:0] log_payload [32];

    always @(negedge clk) begin
        if (bus.cmd_valid && bus.err_valid) both_high = 1'b1;
        if (bus.cmd_valid) begin
            log_code[n_cmd[4:0]]    = bus.cmd_code;
            log_arg[n_cmd[4:0]]     = bus.cmd_arg;
            log_payload[n_cmd[4:0]] = bus.cmd_payload;
            cmd_cyc = cyc;
            n_cmd++;
        end
        if (bus.err_valid) begin
            last_err = bus.err_code;
            err_cyc  = cyc;
            n_err++;
        end
    end

    task automatic drive(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++;
        if ({bus.cmd_valid, bus.err_valid, bus.err_code} !== 4'b0) begin
            fails++;
            $display("FAIL reset_strobes: got %b want 0000", {bus.cmd_valid, bus.err_valid, bus.err_code});
        end
        tests++;
        if ({bus.cmd_code, bus.cmd_arg, bus.cmd_payload} !== 144'h0) begin
            fails++;
            $display("FAIL reset_data: got %h want 0", {bus.cmd_code, bus.cmd_arg, bus.cmd_payload});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        gap(2);
    endtask

    task automatic test_short_frame;
        int c0;
        int end_cyc;
        c0 = n_cmd;
        drive(8'h41); gap(3);
        drive(8'h43); gap(3);
        drive(8'h41);
        end_cyc = cyc;
        gap(4);
        tests++;
        if (n_cmd !== c0 + 1) begin
            fails++;
            $display("FAIL short_count: got %0d want %0d", n_cmd - c0, 1);
        end
        tests++;
        if (cmd_cyc !== end_cyc) begin
            fails++;
            $display("FAIL short_latency: got cycle %0d want %0d", cmd_cyc, end_cyc);
        end
        tests++;
        if ({log_code[c0[4:0]], log_arg[c0[4:0]], log_payload[c0[4:0]]} !== {8'h41, 8'h43, 128'h43}) begin
            fails++;
            $display("FAIL short_fields: got %h %h %h want 41 43 43", log_code[c0[4:0]], log_arg[c0[4:0]], log_payload[c0[4:0]]);
        end
    endtask

    task automatic test_long_frame;
        int c0;
        c0 = n_cmd;
        drive(8'h42);
        for (int i = 1; i <= 16; i++) drive(8'(i));
        drive(8'h42);
        gap(3);
        tests++;
        if (n_cmd !== c0 + 1 || log_code[c0[4:0]] !== 8'h42) begin
            fails++;
            $display("FAIL long_code: got n=%0d code=%h want n=1 code=42", n_cmd - c0, log_code[c0[4:0]]);
        end
        tests++;
        if (log_payload[c0[4:0]] !== 128'h100F0E0D0C0B0A090807060504030201) begin
            fails++;
            $display("FAIL long_payload: got %h want 100f0e0d0c0b0a090807060504030201", log_payload[c0[4:0]]);
        end
    endtask

    task automatic test_mismatch;
        int c0;
        int e0;
        c0 = n_cmd;
        e0 = n_err;
        drive(8'h41); drive(8'h45); drive(8'h42);
        gap(2);
        tests++;
        if (n_err !== e0 + 1 || last_err !== 2'd2 || n_cmd !== c0) begin
            fails++;
            $display("FAIL mismatch_err: got errs=%0d code=%0d cmds=%0d want 1 2 0", n_err - e0, last_err, n_cmd - c0);
        end
        @(negedge clk);
        tests++;
        if (bus.cmd_code !== 8'h42 || bus.cmd_payload !== 128'h100F0E0D0C0B0A090807060504030201) begin
            fails++;
            $display("FAIL mismatch_hold: got %h %h want 42 and long payload", bus.cmd_code, bus.cmd_payload);
        end
        @(posedge clk); #1;
        drive(8'h41); drive(8'h60); drive(8'h41);
        gap(2);
        tests++;
        if (n_cmd !== c0 + 1 || log_arg[c0[4:0]] !== 8'h60 || log_payload[c0[4:0]] !== 128'h60) begin
            fails++;
            $display("FAIL after_mismatch: got n=%0d arg=%h payload=%h want 1 60 60", n_cmd - c0, log_arg[c0[4:0]], log_payload[c0[4:0]]);
        end
    endtask

    task automatic test_unknown;
        int c0;
        int e0;
        int end_cyc;
        c0 = n_cmd;
        e0 = n_err;
        drive(8'h5A);
        end_cyc = cyc;
        gap(2);
        tests++;
        if (n_err !== e0 + 1 || last_err !== 2'd1 || err_cyc !== end_cyc) begin
            fails++;
            $display("FAIL unknown_err: got errs=%0d code=%0d cyc=%0d want 1 1 %0d", n_err - e0, last_err, err_cyc, end_cyc);
        end
        drive(8'h41); drive(8'h7E); drive(8'h41);
        gap(2);
        tests++;
        if (n_cmd !== c0 + 1 || log_arg[c0[4:0]] !== 8'h7E) begin
            fails++;
            $display("FAIL after_unknown: got n=%0d arg=%h want 1 7e", n_cmd - c0, log_arg[c0[4:0]]);
        end
    endtask

    task automatic test_timeout;
        int c0;
        int e0;
        int k;
        c0 = n_cmd;
        e0 = n_err;
        drive(8'h40);
        for (int i = 1; i <= 4; i++) drive(8'(8'h20 + i));
        k = cyc;
        for (int i = 0; i < 150 && n_err == e0; i++) @(negedge clk);
        @(posedge clk); #1;
        tests++;
        if (n_err !== e0 + 1 || last_err !== 2'd3) begin
            fails++;
            $display("FAIL timeout_err: got errs=%0d code=%0d want 1 3", n_err - e0, last_err);
        end
        tests++;
        if (err_cyc !== k + 100 || n_cmd !== c0) begin
            fails++;
            $display("FAIL timeout_cycle: got cyc=%0d cmds=%0d want %0d 0", err_cyc, n_cmd - c0, k + 100);
        end
        drive(8'h41); drive(8'h22); drive(8'h41);
        gap(2);
        tests++;
        if (n_cmd !== c0 + 1 || log_arg[c0[4:0]] !== 8'h22) begin
            fails++;
            $display("FAIL after_timeout: got n=%0d arg=%h want 1 22", n_cmd - c0, log_arg[c0[4:0]]);
        end
    endtask

    task automatic test_reset_mid_frame;
        int c0;
        int e0;
        c0 = n_cmd;
        e0 = n_err;
        drive(8'h43);
        for (int i = 1; i <= 7; i++) drive(8'(i));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        gap(2);
        tests++;
        if (n_cmd !== c0 || n_err !== e0 || bus.cmd_code !== 8'h00) begin
            fails++;
            $display("FAIL reset_mid: got cmds=%0d errs=%0d code=%h want 0 0 00", n_cmd - c0, n_err - e0, bus.cmd_code);
        end
        drive(8'h44);
        for (int i = 0; i < 16; i++) drive(8'(8'hF0 + i));
        drive(8'h44);
        gap(2);
        tests++;
        if (n_cmd !== c0 + 1 || log_code[c0[4:0]] !== 8'h44 ||
            log_payload[c0[4:0]] !== 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0) begin
            fails++;
            $display("FAIL after_reset: got n=%0d code=%h payload=%h want 1 44 fffe..f1f0", n_cmd - c0, log_code[c0[4:0]], log_payload[c0[4:0]]);
        end
    endtask

    task automatic test_back_to_back;
        int c0;
        int e0;
        c0 = n_cmd;
        e0 = n_err;
        drive(8'h41); drive(8'h11); drive(8'h41);
        drive(8'h45); drive(8'h45); drive(8'h41);
        for (int i = 3; i <= 16; i++) drive(8'(i));
        drive(8'h45);
        drive(8'h41); drive(8'h33); drive(8'h41);
        gap(3);
        tests++;
        if (n_cmd !== c0 + 3 || n_err !== e0) begin
            fails++;
            $display("FAIL b2b_count: got cmds=%0d errs=%0d want 3 0", n_cmd - c0, n_err - e0);
        end
        tests++;
        if (log_arg[c0[4:0]] !== 8'h11 || log_code[5'(c0 + 1)] !== 8'h45 || log_arg[5'(c0 + 2)] !== 8'h33) begin
            fails++;
            $display("FAIL b2b_fields: got %h %h %h want 11 45 33", log_arg[c0[4:0]], log_code[5'(c0 + 1)], log_arg[5'(c0 + 2)]);
        end
        tests++;
        if (log_payload[5'(c0 + 1)] !== 128'h100F0E0D0C0B0A090807060504034145) begin
            fails++;
            $display("FAIL code_as_data: got %h want 100f0e0d0c0b0a090807060504034145", log_payload[5'(c0 + 1)]);
        end
        tests++;
        if (both_high !== 1'b0) begin
            fails++;
            $display("FAIL exclusive_strobes: got %b want 0", both_high);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests        = 0;
        fails        = 0;
        cyc          = 0;
        n_cmd        = 0;
        n_err        = 0;
        cmd_cyc      = -1;
        err_cyc      = -1;
        last_err     = 2'd0;
        both_high    = 1'b0;
        reset        = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        test_reset;
        test_short_frame;
        test_long_frame;
        test_mismatch;
        test_unknown;
        test_timeout;
        test_reset_mid_frame;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
